// File: rtl/genie_pkg.sv
// Shared widths and types for the Genie memory datapath.
package genie_pkg;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StFin
    } rs_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [PtrW:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so a push into a full FIFO is fine in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/mem_read_stream.sv
// Burst read engine: issues one SRAM read per word and streams the returned
// words out in order through a decoupling FIFO, tagging the final word.
module mem_read_stream
    import genie_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rvalid,
    input  logic              rready,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    rs_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              rvalid_q, rvalid_d;
    logic              done_q, done_d;

    logic [CntW-1:0]   fifo_count;
    logic [DATA_W:0]   fifo_rdata;
    logic              fifo_empty;
    logic              req_fire, pop, push_last;
    logic [CntW:0]     count_next;

    assign req_fire  = rvalid_q && rready;
    assign pop       = !fifo_empty && dout_ready;
    assign push_last = (remain_q == LEN_W'(1));
    // Occupancy after this edge; lets the next request issue back-to-back.
    assign count_next = {1'b0, fifo_count} + (CntW + 1)'(req_fire) - (CntW + 1)'(pop);

    sync_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (req_fire),
        .push_data({rdata, push_last}),
        .pop      (pop),
        .pop_data (fifo_rdata),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    remain_d = cmd_len;
                    state_d  = (cmd_len == '0) ? StFin : StFetch;
                end
            end
            StFetch: begin
                if (req_fire) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                    if (push_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && fifo_rdata[0]) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // An outstanding request cannot be withdrawn: no push means count only falls.
        rvalid_d = (state_d == StFetch) && (remain_d != '0)
                   && (count_next < (CntW + 1)'(FIFO_DEPTH));
        done_d   = (state_d == StFin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign rvalid     = rvalid_q;
    assign raddr      = addr_q;
    assign dout_valid = !fifo_empty;
    assign dout_data  = fifo_rdata[DATA_W:1];
    assign dout_last  = fifo_rdata[0];
    assign done       = done_q;

endmodule

// File: tb/tb_mem_read_stream.sv
// Randomised bench for mem_read_stream: SRAM responder with variable latency,
// random consumer back-pressure, and a per-cycle behavioural scoreboard.
module tb_mem_read_stream;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LEN_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [25:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        rvalid;
    logic        rready;
    logic [25:0] raddr;
    logic [31:0] rdata;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic        dout_last;
    logic        busy;
    logic        done;

    mem_read_stream #(
        .FIFO_DEPTH(DEPTH),
        .LEN_W     (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .rvalid    (rvalid),
        .rready    (rready),
        .raddr     (raddr),
        .rdata     (rdata),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data),
        .dout_last (dout_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus knobs
    int lat_min = 1;
    int lat_max = 1;
    int ready_mode = 1;   // 0: stall, 1: always ready, 2: random

    // Behavioural model state
    int          phase;       // 0 idle, 1 burst in progress, 2 done cycle
    int          req_left;
    logic [25:0] req_addr;
    int          model_cnt;
    logic [32:0] exp_out[$];

    // Observation log for literal checks
    logic [25:0] req_log[$];
    int hs_cnt, out_words, last_words, last_at, done_cnt, rvalid_cycles;

    function automatic logic [31:0] mem_word(input logic [25:0] a);
        return {a[5:0], a} ^ 32'hC3A5_0F96;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        req_log.delete();
        hs_cnt = 0; out_words = 0; last_words = 0; last_at = 0;
        done_cnt = 0; rvalid_cycles = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && cmd_ready !== 1'b1; i++) step(1);
        check({"timeout_", name}, cmd_ready, 1'b1);
    endtask

    task automatic send_cmd(input logic [25:0] a, input logic [15:0] l);
        wait_idle("pre_cmd", 500);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        step(1);
        cmd_valid = 1'b0;
    endtask

    // SRAM: rready comes on the L-th cycle of a request, L drawn per request.
    initial begin
        int cnt;
        bit in_req;
        rready = 1'b0;
        rdata  = '0;
        in_req = 1'b0;
        cnt    = 0;
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    cnt    = $urandom_range(lat_max, lat_min);
                end
                cnt--;
                if (cnt <= 0) begin
                    rready = 1'b1;
                    rdata  = mem_word(raddr);
                    in_req = 1'b0;
                end else begin
                    rready = 1'b0;
                    rdata  = $urandom;
                end
            end else begin
                rready = 1'b0;
                in_req = 1'b0;
                rdata  = $urandom;
            end
        end
    end

    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dout_ready = 1'b0;
                1:       dout_ready = 1'b1;
                default: dout_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Compare process: model advances once per cycle from the observed handshakes.
    initial begin
        logic        hs, pop, was_last;
        logic [25:0] a;
        phase = 0; req_left = 0; req_addr = '0; model_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check("rst_rvalid", rvalid, 1'b0);
                check("rst_raddr", raddr, 26'h0);
                check("rst_dout_valid", dout_valid, 1'b0);
                check("rst_dout_data", dout_data, 32'h0);
                check("rst_dout_last", dout_last, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                phase = 0; req_left = 0; model_cnt = 0;
                exp_out.delete();
            end else begin
                check("cmd_ready", cmd_ready, phase == 0);
                check("busy", busy, phase != 0);
                check("done", done, phase == 2);
                check("rvalid", rvalid, phase == 1 && req_left > 0 && model_cnt < DEPTH);
                if (rvalid === 1'b1) check("raddr", raddr, req_addr);
                check("dout_valid", dout_valid, model_cnt != 0);
                if (model_cnt != 0) begin
                    if (exp_out.size() == 0) check("dout_extra", 1, 0);
                    else check("dout_word", {dout_data, dout_last}, exp_out[0]);
                end

                hs       = (rvalid === 1'b1) && (rready === 1'b1) && req_left > 0;
                pop      = (model_cnt != 0) && (dout_ready === 1'b1);
                was_last = 1'b0;
                if (rvalid === 1'b1) rvalid_cycles++;
                if (done === 1'b1) done_cnt++;
                if (hs) begin
                    req_log.push_back(raddr);
                    hs_cnt++;
                    req_left--;
                    req_addr = req_addr + 26'd1;
                end
                if (pop && exp_out.size() > 0) begin
                    out_words++;
                    was_last = exp_out[0][0];
                    if (was_last) begin
                        last_words++;
                        last_at = out_words;
                    end
                    void'(exp_out.pop_front());
                end
                model_cnt = model_cnt + int'(hs) - int'(pop);

                case (phase)
                    0: if (cmd_valid === 1'b1) begin
                        a = cmd_addr;
                        for (int i = 0; i < int'(cmd_len); i++) begin
                            exp_out.push_back({mem_word(a), i == int'(cmd_len) - 1});
                            a = a + 26'd1;
                        end
                        req_left = int'(cmd_len);
                        req_addr = cmd_addr;
                        phase    = (cmd_len == 0) ? 2 : 1;
                    end
                    1: if (was_last) phase = 2;
                    default: phase = 0;
                endcase
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] wrap_exp [4];
        int          len;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        clear_log();
        step(3);
        rst_n = 1'b1;
        step(1);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rvalid", rvalid, 1'b0);

        // Basic burst, latency 3
        lat_min = 3; lat_max = 3; ready_mode = 1;
        clear_log();
        send_cmd(26'h000100, 16'd4);
        wait_idle("t1", 200);
        check("t1_reqs", hs_cnt, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_raddr%0d", i), req_log[i], 26'h100 + i);
        check("t1_words", out_words, 4);
        check("t1_lasts", last_words, 1);
        check("t1_last_pos", last_at, 4);
        check("t1_done", done_cnt, 1);

        // Zero-length burst
        clear_log();
        send_cmd(26'h000055, 16'd0);
        check("t2_done_pulse", done, 1'b1);
        step(1);
        check("t2_cmd_ready", cmd_ready, 1'b1);
        check("t2_done_low", done, 1'b0);
        check("t2_no_rvalid", rvalid_cycles, 0);
        check("t2_done_cnt", done_cnt, 1);

        // Address wrap
        wrap_exp[0] = 26'h3FFFFFE; wrap_exp[1] = 26'h3FFFFFF;
        wrap_exp[2] = 26'h0000000; wrap_exp[3] = 26'h0000001;
        lat_min = 1; lat_max = 4;
        clear_log();
        send_cmd(26'h3FFFFFE, 16'd4);
        wait_idle("t3", 200);
        for (int i = 0; i < 4; i++) check($sformatf("t3_raddr%0d", i), req_log[i], wrap_exp[i]);
        check("t3_words", out_words, 4);

        // Back-pressure fills the FIFO, then drains
        lat_min = 1; lat_max = 2; ready_mode = 0;
        clear_log();
        send_cmd(26'h002000, 16'd10);
        step(40);
        check("t4_reqs_stalled", hs_cnt, 4);
        check("t4_rvalid_low", rvalid, 1'b0);
        check("t4_dout_valid", dout_valid, 1'b1);
        ready_mode = 1;
        wait_idle("t4", 300);
        check("t4_reqs", hs_cnt, 10);
        check("t4_words", out_words, 10);
        check("t4_done", done_cnt, 1);

        // Reset mid-burst, then a clean burst
        lat_min = 1; lat_max = 1; ready_mode = 0;
        clear_log();
        send_cmd(26'h004000, 16'd8);
        for (int i = 0; i < 50 && hs_cnt < 2; i++) step(1);
        check("t5_setup", hs_cnt >= 2, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rvalid", rvalid, 1'b0);
        check("t5_dout_valid", dout_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        step(2);
        rst_n = 1'b1;
        ready_mode = 1;
        clear_log();
        send_cmd(26'h005000, 16'd2);
        wait_idle("t5", 100);
        check("t5_words", out_words, 2);
        check("t5_reqs", hs_cnt, 2);
        check("t5_done", done_cnt, 1);

        // Long random burst
        lat_min = 1; lat_max = 6; ready_mode = 2;
        clear_log();
        send_cmd(26'($urandom), 16'd200);
        wait_idle("t6", 4000);
        check("t6_words", out_words, 200);
        check("t6_reqs", hs_cnt, 200);
        check("t6_done", done_cnt, 1);

        // Short random bursts
        for (int k = 0; k < 6; k++) begin
            lat_min = $urandom_range(3, 1);
            lat_max = lat_min + $urandom_range(3, 0);
            len = $urandom_range(12, 0);
            clear_log();
            send_cmd(26'($urandom), 16'(len));
            wait_idle($sformatf("t7_%0d", k), 600);
            check($sformatf("t7_words%0d", k), out_words, len);
            check($sformatf("t7_done%0d", k), done_cnt, 1);
        end

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
